// File: rtl/button_event_arbiter.sv
// Serializes toggle-per-press button events into a one-deep valid/ready slot, granting round-robin.
// Optional saturating lost-event counter and drop_cnt port: define BTN_ARB_DROP_CNT_EN.
module button_event_arbiter #(
    parameter int N_BTN = 4,
    parameter int ID_W  = 2
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [N_BTN-1:0] btn_level,
    input  logic             flush,
    output logic             evt_valid,
    output logic [ID_W-1:0]  evt_id,
    input  logic             evt_ready
`ifdef BTN_ARB_DROP_CNT_EN
    ,
    output logic [7:0]       drop_cnt
`endif
);

    logic [N_BTN-1:0] prev_q, prev_d;
    logic [N_BTN-1:0] pending_q, pending_d;
    logic             primed_q, primed_d;
    logic [ID_W-1:0]  rr_ptr_q, rr_ptr_d;
    logic             evt_valid_q, evt_valid_d;
    logic [ID_W-1:0]  evt_id_q, evt_id_d;

    logic [N_BTN-1:0] chg;
    logic [N_BTN-1:0] grant_vec;
    logic [ID_W-1:0]  winner;
    logic             found;
    logic             free;
    logic             grant;

    // Round-robin search: first pending channel at or above rr_ptr, wrapping at N_BTN-1.
    always_comb begin
        int idx;
        idx    = 0;
        winner = '0;
        found  = 1'b0;
        for (int k = 0; k < N_BTN; k++) begin
            idx = (int'(rr_ptr_q) + k) % N_BTN;
            if (!found && pending_q[idx]) begin
                found  = 1'b1;
                winner = ID_W'(idx);
            end
        end
    end

    always_comb begin
        chg       = primed_q ? (btn_level ^ prev_q) : '0;
        free      = !evt_valid_q || evt_ready;
        grant     = free && found;
        grant_vec = grant ? (N_BTN'(1) << winner) : '0;
    end

    always_comb begin
        prev_d      = btn_level;
        primed_d    = 1'b1;
        // A press arriving on the channel being granted survives the grant-clear.
        pending_d   = (pending_q & ~grant_vec) | chg;
        rr_ptr_d    = rr_ptr_q;
        evt_valid_d = evt_valid_q;
        evt_id_d    = evt_id_q;
        if (free) begin
            evt_valid_d = found;
            if (grant) begin
                evt_id_d = winner;
                rr_ptr_d = (winner == ID_W'(N_BTN - 1)) ? '0 : ID_W'(winner + 1'b1);
            end
        end
        if (flush) begin
            pending_d   = '0;
            evt_valid_d = 1'b0;
            rr_ptr_d    = '0;
            evt_id_d    = evt_id_q;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            prev_q      <= '0;
            pending_q   <= '0;
            primed_q    <= 1'b0;
            rr_ptr_q    <= '0;
            evt_valid_q <= 1'b0;
            evt_id_q    <= '0;
        end else begin
            prev_q      <= prev_d;
            pending_q   <= pending_d;
            primed_q    <= primed_d;
            rr_ptr_q    <= rr_ptr_d;
            evt_valid_q <= evt_valid_d;
            evt_id_q    <= evt_id_d;
        end
    end

    assign evt_valid = evt_valid_q;
    assign evt_id    = evt_id_q;

`ifdef BTN_ARB_DROP_CNT_EN
    logic [7:0]       drop_cnt_q, drop_cnt_d;
    logic [N_BTN-1:0] drop_vec;

    function automatic logic [7:0] sat_add8(input logic [7:0] base, input logic [N_BTN-1:0] hits);
        int sum;
        sum = int'(base) + $countones(hits);
        return (sum > 255) ? 8'hFF : 8'(sum);
    endfunction

    // A press on an already-pending channel merges into it and is counted as lost; flushed edges are not.
    always_comb begin
        drop_vec   = chg & pending_q & ~grant_vec;
        drop_cnt_d = flush ? drop_cnt_q : sat_add8(drop_cnt_q, drop_vec);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            drop_cnt_q <= '0;
        end else begin
            drop_cnt_q <= drop_cnt_d;
        end
    end

    assign drop_cnt = drop_cnt_q;
`endif

endmodule

// File: tb/tb_button_event_arbiter.sv
// Randomized and directed bench for button_event_arbiter against a bit-array behavioural model.
module tb_button_event_arbiter;

    localparam int N = 4;

    logic         clk = 1'b0;
    logic         reset = 1'b1;
    logic [N-1:0] btn_level = '0;
    logic         flush = 1'b0;
    logic         evt_valid;
    logic [1:0]   evt_id;
    logic         evt_ready = 1'b0;
`ifdef BTN_ARB_DROP_CNT_EN
    logic [7:0]   drop_cnt;
`endif

    button_event_arbiter #(.N_BTN(N), .ID_W(2)) dut (
        .clk       (clk),
        .reset     (reset),
        .btn_level (btn_level),
        .flush     (flush),
        .evt_valid (evt_valid),
        .evt_id    (evt_id),
        .evt_ready (evt_ready)
`ifdef BTN_ARB_DROP_CNT_EN
        ,
        .drop_cnt  (drop_cnt)
`endif
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;

    task automatic chk(input string name, input int act, input int exp);
        n_checks++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
    endtask

    // Behavioural model: per-channel pending flags, a last-seen level per channel, and a slot.
    bit m_prev[N];
    bit m_pend[N];
    bit m_primed;
    int m_rr;
    bit m_valid;
    int m_id;
    int m_drops;
    bit cmp_en = 1'b0;

    always @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < N; i++) begin
                m_prev[i] = 0;
                m_pend[i] = 0;
            end
            m_primed = 0; m_rr = 0; m_valid = 0; m_id = 0; m_drops = 0;
            cmp_en = 1'b1;
        end else begin
            bit pressed[N];
            bit can_take;
            int win;
            can_take = !m_valid || evt_ready;
            for (int i = 0; i < N; i++)
                pressed[i] = m_primed && (btn_level[i] != m_prev[i]);
            if (flush) begin
                for (int i = 0; i < N; i++) m_pend[i] = 0;
                m_valid = 0;
                m_rr = 0;
            end else begin
                win = -1;
                if (can_take) begin
                    for (int k = 0; k < N; k++)
                        if (win < 0 && m_pend[(m_rr + k) % N]) win = (m_rr + k) % N;
                    m_valid = (win >= 0);
                    if (win >= 0) begin
                        m_id = win;
                        m_pend[win] = 0;
                        m_rr = (win + 1) % N;
                    end
                end
                for (int i = 0; i < N; i++) begin
                    if (pressed[i]) begin
                        if (m_pend[i]) m_drops = (m_drops < 255) ? m_drops + 1 : 255;
                        m_pend[i] = 1;
                    end
                end
            end
            for (int i = 0; i < N; i++) m_prev[i] = btn_level[i];
            m_primed = 1;
        end
    end

    always @(negedge clk) begin
        if (cmp_en) begin
            chk("model_valid", int'(evt_valid), int'(m_valid));
            if (m_valid) chk("model_id", int'(evt_id), m_id);
`ifdef BTN_ARB_DROP_CNT_EN
            chk("model_drop", int'(drop_cnt), m_drops);
`endif
        end
    end

    task automatic cyc();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic chk_drop(input string name, input int exp);
`ifdef BTN_ARB_DROP_CNT_EN
        chk(name, int'(drop_cnt), exp);
`else
        if (exp < 0) $display("unexpected negative drop expectation in %s", name);
`endif
    endtask

    initial begin
        // Priming: nonzero level at reset release is not a press.
        btn_level = 4'b0101;
        reset = 1'b1;
        cyc(); cyc();
        reset = 1'b0;
        evt_ready = 1'b1;
        cyc();
        for (int i = 0; i < 10; i++) begin
            cyc();
            chk("prime_valid", int'(evt_valid), 0);
        end
        chk_drop("prime_drop", 0);

        // Single press latency.
        btn_level[2] = ~btn_level[2];
        cyc();
        chk("lat_k_valid", int'(evt_valid), 0);
        cyc();
        chk("lat_k1_valid", int'(evt_valid), 1);
        chk("lat_k1_id", int'(evt_id), 2);
        cyc();
        chk("lat_k2_valid", int'(evt_valid), 0);

        // Round-robin from rr_ptr=0 (flush resets the pointer).
        flush = 1'b1;
        cyc();
        flush = 1'b0;
        btn_level = btn_level ^ 4'b1111;
        cyc();
        for (int i = 0; i < 4; i++) begin
            cyc();
            chk("rr_all_valid", int'(evt_valid), 1);
            chk("rr_all_id", int'(evt_id), i);
        end
        cyc();
        chk("rr_all_done", int'(evt_valid), 0);
        btn_level = btn_level ^ 4'b1001;
        cyc();
        cyc();
        chk("rr_03_first", int'(evt_id), 0);
        cyc();
        chk("rr_03_second", int'(evt_id), 3);
        cyc();
        chk("rr_03_done", int'(evt_valid), 0);

        // Backpressure and drop.
        evt_ready = 1'b0;
        btn_level[1] = ~btn_level[1];
        cyc();
        cyc();
        chk("bp_valid", int'(evt_valid), 1);
        chk("bp_id", int'(evt_id), 1);
        btn_level[1] = ~btn_level[1];
        cyc();
        chk("bp_hold_id", int'(evt_id), 1);
        chk_drop("bp_drop0", 0);
        btn_level[1] = ~btn_level[1];
        cyc();
        chk("bp_hold2_valid", int'(evt_valid), 1);
        chk_drop("bp_drop1", 1);
        evt_ready = 1'b1;
        cyc();
        chk("bp_second_valid", int'(evt_valid), 1);
        chk("bp_second_id", int'(evt_id), 1);
        cyc();
        chk("bp_done", int'(evt_valid), 0);

        // Press on a channel in the same cycle it is granted.
        btn_level[3] = ~btn_level[3];
        cyc();
        btn_level[3] = ~btn_level[3];
        cyc();
        chk("sim_first_id", int'(evt_id), 3);
        cyc();
        chk("sim_second_valid", int'(evt_valid), 1);
        chk("sim_second_id", int'(evt_id), 3);
        cyc();
        chk("sim_done", int'(evt_valid), 0);
        chk_drop("sim_drop", 1);

        // Flush mid-stream.
        evt_ready = 1'b0;
        btn_level = btn_level ^ 4'b0111;
        cyc();
        cyc();
        chk("fl_pre_valid", int'(evt_valid), 1);
        flush = 1'b1;
        cyc();
        flush = 1'b0;
        chk("fl_valid", int'(evt_valid), 0);
        evt_ready = 1'b1;
        for (int i = 0; i < 5; i++) begin
            cyc();
            chk("fl_quiet", int'(evt_valid), 0);
        end

        // Reset mid-stream, then re-priming.
        evt_ready = 1'b0;
        btn_level = btn_level ^ 4'b0111;
        cyc();
        cyc();
        btn_level[1] = ~btn_level[1];
        cyc();
        chk_drop("rs_pre_drop", 2);
        reset = 1'b1;
        cyc();
        reset = 1'b0;
        chk("rs_valid", int'(evt_valid), 0);
        chk_drop("rs_drop", 0);
        btn_level[0] = ~btn_level[0];
        cyc();
        evt_ready = 1'b1;
        cyc(); cyc();
        chk("rs_prime_quiet", int'(evt_valid), 0);

        // Randomized traffic.
        for (int c = 0; c < 4000; c++) begin
            logic [N-1:0] tog;
            tog = '0;
            for (int i = 0; i < N; i++) tog[i] = ($urandom_range(0, 3) == 0);
            btn_level = btn_level ^ tog;
            evt_ready = ($urandom_range(0, 9) < 7);
            flush     = ($urandom_range(0, 49) == 0);
            reset     = ($urandom_range(0, 99) == 0);
            cyc();
        end
        reset = 1'b0;
        flush = 1'b0;
        cyc();

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
